// File: rtl/tone_gen.sv
// Square-wave tone generator: a sequential restoring divider turns a note frequency into a
// half-period cycle count, and a counter toggles the output once per half period.
module tone_gen #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned FREQ_W = 12,
  parameter int unsigned DIV_W  = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq,
  input  logic              en,
  output logic              audio_out,
  output logic              period_tick,
  output logic              busy,
  output logic [DIV_W-1:0]  half_period
);

  localparam int unsigned      CntW     = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] Dividend = DIV_W'(CLK_HZ);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e            state_q;
  logic [FREQ_W-1:0] freq_l_q;
  logic [DIV_W-1:0]  pending_q, dvd_q, quo_q, cnt_q;
  logic [FREQ_W:0]   dvs_q, rem_q, rem_sub;
  logic [FREQ_W+1:0] rem_sh;
  logic [CntW-1:0]   bit_cnt_q;
  logic              rem_ge, running_q;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DIV_W-1]};
    rem_ge  = rem_sh >= {1'b0, dvs_q};
    rem_sub = (FREQ_W+1)'(rem_sh - {1'b0, dvs_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      freq_l_q  <= '0;
      pending_q <= '0;
      busy      <= 1'b0;
      dvd_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      bit_cnt_q <= '0;
    end else if (freq == '0) begin
      state_q   <= StIdle;
      freq_l_q  <= '0;
      pending_q <= '0;
      busy      <= 1'b0;
    end else if (state_q != StDone && freq != freq_l_q) begin
      // New pitch while idle or mid-division: (re)start from the top.
      state_q   <= StDiv;
      freq_l_q  <= freq;
      busy      <= 1'b1;
      dvd_q     <= Dividend;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= {freq, 1'b0};
      bit_cnt_q <= CntW'(DIV_W);
    end else begin
      unique case (state_q)
        StIdle: ;
        StDiv: begin
          rem_q     <= rem_ge ? rem_sub : rem_sh[FREQ_W:0];
          quo_q     <= {quo_q[DIV_W-2:0], rem_ge};
          dvd_q     <= {dvd_q[DIV_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q - CntW'(1);
          if (bit_cnt_q == CntW'(1)) state_q <= StDone;
        end
        StDone: begin
          pending_q <= (quo_q == '0) ? DIV_W'(1) : quo_q;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // running_q distinguishes a re-enabled wave from the normal low half of a running one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_out   <= 1'b0;
      period_tick <= 1'b0;
      half_period <= '0;
      cnt_q       <= '0;
      running_q   <= 1'b0;
    end else if (!en) begin
      audio_out   <= 1'b0;
      period_tick <= 1'b0;
      cnt_q       <= '0;
      running_q   <= 1'b0;
    end else if (half_period == '0) begin
      if (pending_q != '0) begin
        half_period <= pending_q;
        cnt_q       <= '0;
        audio_out   <= 1'b1;
        period_tick <= 1'b1;
        running_q   <= 1'b1;
      end else begin
        period_tick <= 1'b0;
      end
    end else if (!running_q) begin
      audio_out   <= 1'b1;
      period_tick <= 1'b1;
      cnt_q       <= '0;
      running_q   <= 1'b1;
    end else if (cnt_q == half_period - DIV_W'(1)) begin
      cnt_q <= '0;
      if (pending_q == '0) begin
        half_period <= '0;
        audio_out   <= 1'b0;
        period_tick <= 1'b0;
        running_q   <= 1'b0;
      end else begin
        half_period <= pending_q;
        audio_out   <= ~audio_out;
        period_tick <= ~audio_out;
      end
    end else begin
      cnt_q       <= cnt_q + DIV_W'(1);
      period_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: a scoreboard of expected half_period values drained by a monitor,
// plus per-cycle waveform checks on half-cycle length and period_tick.
module tb_tone_gen;

  localparam int unsigned ClkHz = 8800;
  localparam int unsigned FreqW = 12;
  localparam int unsigned DivW  = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [FreqW-1:0] freq = '0;
  logic             audio_out, period_tick, busy;
  logic [DivW-1:0]  half_period;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned exp_q[$];
  int unsigned last_push = 0;
  bit          mon_on = 1'b0;

  logic            prev_audio = 1'b0;
  logic [DivW-1:0] prev_hp = '0;
  logic [DivW-1:0] run_hp = '0;
  int              run_len = 0;
  bit              seg_dirty = 1'b1;

  tone_gen #(
    .CLK_HZ(ClkHz),
    .FREQ_W(FreqW),
    .DIV_W (DivW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .freq       (freq),
    .en         (en),
    .audio_out  (audio_out),
    .period_tick(period_tick),
    .busy       (busy),
    .half_period(half_period)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned model_hp(input int unsigned f);
    int unsigned q;
    if (f == 0) return 0;
    q = ClkHz / (2 * f);
    return (q == 0) ? 1 : q;
  endfunction

  task automatic push_freq(input int unsigned f);
    int unsigned e;
    e = model_hp(f);
    freq = FreqW'(f);
    if (e != last_push) begin
      exp_q.push_back(e);
      last_push = e;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_settle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    step();
    check({name, "_hp"}, half_period, last_push);
  endtask

  // Monitor: half-cycle lengths, tick-on-rise, and the expected half_period sequence.
  always @(negedge clk) begin
    if (mon_on) begin
      check("tick", period_tick, audio_out && !prev_audio);
      if (audio_out != prev_audio) begin
        if (!seg_dirty && run_hp != '0) check("half_len", run_len, run_hp);
        run_len   = 1;
        run_hp    = half_period;
        seg_dirty = !en;
      end else begin
        run_len++;
        if (!en) seg_dirty = 1'b1;
      end
      if (half_period != prev_hp) begin
        if (exp_q.size() == 0) check("hp_unexpected", half_period, prev_hp);
        else check("hp_seq", half_period, exp_q.pop_front());
        if (half_period == '0) run_hp = '0;
        prev_hp = half_period;
      end
      prev_audio = audio_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, busy_n, ticks, f;
    bit lo_seen;

    repeat (2) step();
    check("rst_audio", audio_out, 0);
    check("rst_tick", period_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_hp", half_period, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    mon_on = 1'b1;

    // Start from silence: latency and busy length.
    push_freq(440);
    edges  = 0;
    busy_n = 0;
    while (half_period == '0 && edges < 100) begin
      step();
      edges++;
      if (busy) busy_n++;
    end
    check("start_latency", edges, DivW + 3);
    check("start_audio", audio_out, 1);
    check("start_tick", period_tick, 1);
    check("busy_len", (busy_n >= DivW && busy_n <= DivW + 1), 1);
    repeat (100) step();
    wait_settle("f440");

    push_freq(261);
    wait_settle("f261");
    repeat (80) step();

    // Restarted division: the aborted pitch must never reach half_period.
    push_freq(440);
    wait_settle("f440b");
    repeat (7) step();
    freq = FreqW'(300);
    repeat (5) step();
    push_freq(262);
    busy_n = 0;
    step();
    while (busy && busy_n < 100) begin
      busy_n++;
      step();
    end
    check("restart_busy_len", (busy_n >= DivW && busy_n <= DivW + 1), 1);
    wait_settle("f262");
    repeat (50) step();

    // Mute for 37 cycles and resume.
    push_freq(440);
    wait_settle("f440c");
    repeat (13) step();
    en = 1'b0;
    step();
    check("mute_audio", audio_out, 0);
    check("mute_tick", period_tick, 0);
    check("mute_hp", half_period, 10);
    repeat (36) step();
    en = 1'b1;
    step();
    check("unmute_audio", audio_out, 1);
    check("unmute_tick", period_tick, 1);
    check("unmute_hp", half_period, 10);
    repeat (60) step();

    for (int i = 0; i < 15; i++) begin
      f = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(50, 4095));
      push_freq(f);
      wait_settle("rand");
      repeat ($urandom_range(0, 40)) step();
    end

    // Stop mid-wave: silence only at the next boundary.
    push_freq(440);
    wait_settle("f440d");
    repeat (4) step();
    push_freq(0);
    step();
    check("stop_defer", half_period, 10);
    wait_settle("stop");
    ticks   = 0;
    lo_seen = 1'b1;
    repeat (60) begin
      step();
      if (period_tick) ticks++;
      if (audio_out) lo_seen = 1'b0;
    end
    check("stop_ticks", ticks, 0);
    check("stop_low", lo_seen, 1);

    // Highest pitch: one-cycle half periods, then an asynchronous reset mid-wave.
    push_freq(4095);
    wait_settle("f4095");
    repeat (20) step();
    @(posedge clk);
    #3;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_audio", audio_out, 0);
    check("arst_tick", period_tick, 0);
    check("arst_busy", busy, 0);
    check("arst_hp", half_period, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream of the switch-to-frequency stage: consumes the registered 12-bit note frequency (Hz) and produces a 50%-duty square wave at that pitch for the audio output pin.
- Converts frequency to a half-period cycle count with an internal sequential restoring divider (CLK_HZ / (2*freq)).
- Drives a half-period counter that toggles the output.
- New pitches take effect glitch-free at the next half-period boundary.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz; the divider's dividend.
- FREQ_W, 12, width of freq input.
- DIV_W, 27, quotient/counter width; must satisfy 2^DIV_W > CLK_HZ. Also the divider latency in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- freq  input  FREQ_W  requested tone frequency in Hz; 0 = silence.
- en  input  1  tone enable; 0 mutes the output.
- audio_out  output  1  square-wave output.
- period_tick  output  1  one-cycle pulse on every low-to-high transition of audio_out.
- busy  output  1  high while a division is in progress.
- half_period  output  DIV_W  half-period count currently driving the counter; 0 = no tone.

Behaviour:
- Reset (rst_n=0, async) clears all state:
  - audio_out=0, period_tick=0, busy=0, half_period=0.
  - Internal freq_l=0, pending value 0, counter 0, FSM=IDLE.
- Divider FSM states: IDLE, DIV, DONE.
- IDLE to DIV:
  - Trigger: freq != freq_l and freq != 0.
  - Action: latch freq_l<=freq, busy<=1, load dividend=CLK_HZ, divisor=2*freq_l (FREQ_W+1 bits), bit counter=DIV_W.
- DIV:
  - One quotient bit per cycle, MSB first, restoring algorithm.
  - Exactly DIV_W cycles, then go to DONE.
  - If freq changes during DIV (freq != freq_l, including to 0), abort and restart:
    - Nonzero new freq: re-enter DIV with the new freq, bit counter reset.
    - freq=0: go to IDLE.
- DONE (one cycle):
  - pending <= quotient, clamped to minimum 1; remainder is discarded (floor).
  - busy<=0, then go to IDLE.
- freq becomes 0 (any state): freq_l<=0 and pending<=0.
- Half-period counter:
  - When half_period!=0 and en=1: cnt increments each cycle.
  - When cnt==half_period-1: cnt<=0 and audio_out toggles.
  - If pending != half_period at that boundary, half_period<=pending at the same edge.
  - The wave therefore never shows a truncated or extended half cycle; the old pitch completes its current half period.
- Starting from silence (half_period==0, including after reset):
  - When pending becomes nonzero with en=1, on the next edge: half_period<=pending, cnt<=0, audio_out<=1, period_tick<=1.
- Stopping:
  - pending==0 at a boundary: half_period<=0, audio_out<=0, counter stops.
  - freq=0 mid-half-period: silence begins at the next boundary, not immediately.
- en=0:
  - audio_out<=0, cnt<=0 on the next edge; half_period retained; divider keeps tracking freq.
  - On the next edge after en returns to 1 with half_period!=0: audio_out<=1, period_tick<=1, cnt<=0.
- period_tick is registered: high exactly on the cycle audio_out first reads 1; never high for two consecutive cycles.
- Latency, freq change to new half_period from IDLE: 1 (latch) + DIV_W + 1 (DONE) cycles, then up to one old half period.
- Simultaneous DONE and a counter boundary on the same edge: the boundary uses the old pending; the new value applies at the following boundary.
- Holding freq constant causes no further divisions.

Test Plan (CLK_HZ=8800, DIV_W=14):
- Reset, en=1, freq=440 → busy high 14 cycles, pending=10, half_period=10 next edge; audio_out=1 with period_tick; toggles every 10 cycles (period 20); tick every 20 cycles.
- Steady 440, then freq=261 → division runs; half_period stays 10 until the current half period ends, then 16 (floor 8800/522); no half cycle other than 10 or 16 observed.
- freq=440 then freq=262 mid-division → division restarts; busy high 14 cycles from the change; final half_period=16 (8800/524); no intermediate value appears.
- Running 440, set freq=0 → audio_out finishes the current half period, then goes low; half_period=0; no further period_tick.
- Running 440, en=0 for 37 cycles then en=1 → audio_out low next edge; on re-enable audio_out=1 and period_tick=1 next edge; 10-cycle half periods resume.
- freq=4095 (8800/8190 floors to 1) → half_period=1, audio_out toggles every cycle. Then assert rst_n=0 mid-wave → all outputs 0 immediately, asynchronously.
